// File: rtl/move_link_pkg.sv
// Shared constants and types for the move_link board-move exchange block:
// cell geometry, frame layout, FSM encoding and small frame helpers.
package move_link_pkg;

  localparam logic [11:0] COL0_HI = 12'd338;
  localparam logic [11:0] COL1_LO = 12'd344;
  localparam logic [11:0] COL1_HI = 12'd679;
  localparam logic [11:0] COL2_LO = 12'd685;
  localparam logic [11:0] COL2_HI = 12'd1023;

  localparam logic [11:0] ROW0_HI = 12'd251;
  localparam logic [11:0] ROW1_LO = 12'd259;
  localparam logic [11:0] ROW1_HI = 12'd507;
  localparam logic [11:0] ROW2_LO = 12'd515;
  localparam logic [11:0] ROW2_HI = 12'd767;

  localparam logic [2:0] FRAME_HDR = 3'b101;
  localparam logic [3:0] IDX_NONE  = 4'hF;
  localparam logic [3:0] IDX_MAX   = 4'd8;

  localparam logic MODE_SENDING   = 1'b0;
  localparam logic MODE_RECEIVING = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TX_WAIT,
    ST_RX_WAIT,
    ST_DONE,
    ST_REARM
  } state_t;

  function automatic logic [8:0] onehot9(input logic [3:0] idx);
    logic [8:0] v;
    v = 9'b0;
    if (idx <= IDX_MAX) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic frame_ok(input logic [7:0] f);
    return (f[7:5] == FRAME_HDR) && (f[3:0] <= IDX_MAX);
  endfunction

endpackage

// File: rtl/move_link_if.sv
// Byte-level handshake between move_link (master) and the UART transceiver (slave).
interface move_link_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output tx_data, tx_start, input tx_done, rx_data, rx_valid);
  modport slave  (input tx_data, tx_start, output tx_done, rx_data, rx_valid);
endinterface

// File: rtl/move_link_square_decoder.sv
// Maps a cursor position onto one of the nine board cells; gaps between
// cells and anything beyond the board decode to no cell.
module square_decoder
  import move_link_pkg::*;
(
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic [3:0]  idx,
  output logic        hit
);

  logic [1:0] col, row;
  logic       col_ok, row_ok;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    col    = 2'd0;
    row    = 2'd0;
    col_ok = 1'b1;
    row_ok = 1'b1;

    if (x <= COL0_HI)                       col = 2'd0;
    else if (x >= COL1_LO && x <= COL1_HI)  col = 2'd1;
    else if (x >= COL2_LO && x <= COL2_HI)  col = 2'd2;
    else                                    col_ok = 1'b0;

    if (y <= ROW0_HI)                       row = 2'd0;
    else if (y >= ROW1_LO && y <= ROW1_HI)  row = 2'd1;
    else if (y >= ROW2_LO && y <= ROW2_HI)  row = 2'd2;
    else                                    row_ok = 1'b0;

    hit = col_ok && row_ok;
    idx = hit ? ({2'b00, row} * 4'd3 + {2'b00, col}) : IDX_NONE;
  end

endmodule

// File: rtl/move_link.sv
// Exchanges one board move per operation over a byte UART: sends the last
// clicked cell, or waits for and validates the opponent's move frame.
module move_link
  import move_link_pkg::*;
(
  input  logic         pclk,
  input  logic         rst,
  input  logic         uart_en,
  input  logic         uart_mode,
  input  logic         playerID,
  input  logic [11:0]  mouse_xpos,
  input  logic [11:0]  mouse_ypos,
  input  logic         mouse_left,
  move_link_if.master  uart,
  output logic         rx_tx_done,
  output logic [8:0]   local_square,
  output logic [8:0]   remote_square,
  output logic         remote_player,
  output logic         frame_err,
  output logic         overrun
);

  state_t     state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic       rx_tx_done_q, rx_tx_done_d;
  logic [8:0] local_square_q, local_square_d;
  logic [8:0] remote_square_q, remote_square_d;
  logic       remote_player_q, remote_player_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       pending_q, pending_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic [3:0] last_click_q, last_click_d;
  logic       last_mode_q, last_mode_d;
  logic       consume;
  logic [3:0] click_idx;
  logic       click_hit;

  square_decoder u_decoder (
    .x   (mouse_xpos),
    .y   (mouse_ypos),
    .idx (click_idx),
    .hit (click_hit)
  );

  always_comb begin
    state_d         = state_q;
    tx_data_d       = tx_data_q;
    tx_start_d      = 1'b0;
    rx_tx_done_d    = 1'b0;
    local_square_d  = local_square_q;
    remote_square_d = remote_square_q;
    remote_player_d = remote_player_q;
    frame_err_d     = 1'b0;
    overrun_d       = 1'b0;
    last_mode_d     = last_mode_q;
    consume         = 1'b0;

    // Dropping uart_en abandons any operation in flight without a completion pulse.
    unique case (state_q)
      ST_IDLE: begin
        if (uart_en) state_d = (uart_mode == MODE_RECEIVING) ? ST_RX_WAIT : ST_LOAD;
      end
      ST_LOAD: begin
        if (!uart_en) begin
          state_d = ST_IDLE;
        end else if (last_click_q == IDX_NONE) begin
          frame_err_d = 1'b1;
          state_d     = ST_REARM;
        end else begin
          tx_data_d      = {FRAME_HDR, playerID, last_click_q};
          tx_start_d     = 1'b1;
          local_square_d = onehot9(last_click_q);
          state_d        = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (!uart_en) begin
          state_d = ST_IDLE;
        end else if (uart.tx_done) begin
          rx_tx_done_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_RX_WAIT: begin
        if (!uart_en) begin
          state_d = ST_IDLE;
        end else if (pending_q) begin
          consume = 1'b1;
          if (frame_ok(rx_buf_q)) begin
            remote_square_d = onehot9(rx_buf_q[3:0]);
            remote_player_d = rx_buf_q[4];
            rx_tx_done_d    = 1'b1;
            state_d         = ST_DONE;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        last_mode_d = uart_mode;
        state_d     = ST_REARM;
      end
      ST_REARM: begin
        if (!uart_en || (uart_mode != last_mode_q)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte arriving in the same cycle the held one is consumed is not an overrun.
    rx_buf_d  = rx_buf_q;
    pending_d = pending_q && !consume;
    if (uart.rx_valid) begin
      rx_buf_d  = uart.rx_data;
      pending_d = 1'b1;
      overrun_d = pending_q && !consume;
    end

    last_click_d = (mouse_left && click_hit) ? click_idx : last_click_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      tx_data_q       <= 8'h00;
      tx_start_q      <= 1'b0;
      rx_tx_done_q    <= 1'b0;
      local_square_q  <= 9'h000;
      remote_square_q <= 9'h000;
      remote_player_q <= 1'b0;
      frame_err_q     <= 1'b0;
      overrun_q       <= 1'b0;
      pending_q       <= 1'b0;
      // NOTE: the one-entry rx buffer is a single register, so it is reset too; a multi-entry store would not be.
      rx_buf_q        <= 8'h00;
      last_click_q    <= IDX_NONE;
      last_mode_q     <= MODE_SENDING;
    end else begin
      state_q         <= state_d;
      tx_data_q       <= tx_data_d;
      tx_start_q      <= tx_start_d;
      rx_tx_done_q    <= rx_tx_done_d;
      local_square_q  <= local_square_d;
      remote_square_q <= remote_square_d;
      remote_player_q <= remote_player_d;
      frame_err_q     <= frame_err_d;
      overrun_q       <= overrun_d;
      pending_q       <= pending_d;
      rx_buf_q        <= rx_buf_d;
      last_click_q    <= last_click_d;
      last_mode_q     <= last_mode_d;
    end
  end

  assign uart.tx_data  = tx_data_q;
  assign uart.tx_start = tx_start_q;
  assign rx_tx_done    = rx_tx_done_q;
  assign local_square  = local_square_q;
  assign remote_square = remote_square_q;
  assign remote_player = remote_player_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_move_link.sv
// Directed bench for move_link: a transaction-level reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_move_link;

  logic        pclk = 1'b0;
  logic        rst;
  logic        uart_en, uart_mode, playerID, mouse_left;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        rx_tx_done, remote_player, frame_err, overrun;
  logic [8:0]  local_square, remote_square;

  move_link_if u_if ();

  move_link dut (
    .pclk          (pclk),
    .rst           (rst),
    .uart_en       (uart_en),
    .uart_mode     (uart_mode),
    .playerID      (playerID),
    .mouse_xpos    (mouse_xpos),
    .mouse_ypos    (mouse_ypos),
    .mouse_left    (mouse_left),
    .uart          (u_if),
    .rx_tx_done    (rx_tx_done),
    .local_square  (local_square),
    .remote_square (remote_square),
    .remote_player (remote_player),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 pclk = ~pclk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_SEND = 1, P_SENDING = 2, P_RECV = 3, P_FINISH = 4, P_HOLD = 5;

  int         m_phase, m_click, m_last_mode;
  int         rx_q[$];
  logic [7:0] m_tx_data;
  logic       m_tx_start, m_done, m_rplayer, m_ferr, m_ovr;
  logic [8:0] m_local, m_remote;

  function automatic int cell_of(input int x, input int y);
    int c, r;
    if (x <= 338) c = 0;
    else if (x >= 344 && x <= 679) c = 1;
    else if (x >= 685 && x <= 1023) c = 2;
    else c = -1;
    if (y <= 251) r = 0;
    else if (y >= 259 && y <= 507) r = 1;
    else if (y >= 515 && y <= 767) r = 2;
    else r = -1;
    return (c < 0 || r < 0) ? -1 : r * 3 + c;
  endfunction

  always @(posedge pclk or negedge rst) begin : model
    int b, cidx;
    if (!rst) begin
      m_phase = P_IDLE; m_click = -1; m_last_mode = 0; rx_q.delete();
      m_tx_data = 8'h00; m_tx_start = 1'b0; m_done = 1'b0; m_local = 9'h000;
      m_remote = 9'h000; m_rplayer = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      m_tx_start = 1'b0; m_done = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      case (m_phase)
        P_IDLE:    if (uart_en) m_phase = uart_mode ? P_RECV : P_SEND;
        P_SEND: begin
          if (!uart_en) m_phase = P_IDLE;
          else if (m_click < 0) begin m_ferr = 1'b1; m_phase = P_HOLD; end
          else begin
            m_tx_data  = 8'(160 + (playerID ? 16 : 0) + m_click);
            m_tx_start = 1'b1;
            m_local    = 9'(1 << m_click);
            m_phase    = P_SENDING;
          end
        end
        P_SENDING: begin
          if (!uart_en) m_phase = P_IDLE;
          else if (u_if.tx_done) begin m_done = 1'b1; m_phase = P_FINISH; end
        end
        P_RECV: begin
          if (!uart_en) m_phase = P_IDLE;
          else if (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            if (b / 32 == 5 && b % 16 <= 8) begin
              m_remote  = 9'(1 << (b % 16));
              m_rplayer = ((b / 16) % 2) == 1;
              m_done    = 1'b1;
              m_phase   = P_FINISH;
            end else m_ferr = 1'b1;
          end
        end
        P_FINISH: begin m_last_mode = int'(uart_mode); m_phase = P_HOLD; end
        P_HOLD:   if (!uart_en || int'(uart_mode) != m_last_mode) m_phase = P_IDLE;
        default:  m_phase = P_IDLE;
      endcase
      if (u_if.rx_valid) begin
        if (rx_q.size() > 0) begin m_ovr = 1'b1; rx_q.delete(); end
        rx_q.push_back(int'(u_if.rx_data));
      end
      cidx = cell_of(int'(mouse_xpos), int'(mouse_ypos));
      if (mouse_left && cidx >= 0) m_click = cidx;
    end
  end

  always @(negedge pclk) begin
    check("tx_data",       u_if.tx_data,  m_tx_data);
    check("tx_start",      u_if.tx_start, m_tx_start);
    check("rx_tx_done",    rx_tx_done,    m_done);
    check("local_square",  local_square,  m_local);
    check("remote_square", remote_square, m_remote);
    check("remote_player", remote_player, m_rplayer);
    check("frame_err",     frame_err,     m_ferr);
    check("overrun",       overrun,       m_ovr);
  end

  int n_txs = 0, n_done = 0;
  always @(negedge pclk) begin
    if (u_if.tx_start) n_txs++;
    if (rx_tx_done) n_done++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic wait_for(input int which, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge pclk);
      case (which)
        0: seen = u_if.tx_start;
        1: seen = rx_tx_done;
        2: seen = frame_err;
        default: seen = overrun;
      endcase
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    u_if.rx_data = b; u_if.rx_valid = 1'b1;
    tick(1);
    u_if.rx_valid = 1'b0;
  endtask

  task automatic click(input int x, input int y);
    mouse_xpos = 12'(x); mouse_ypos = 12'(y); mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_tx_data"},  u_if.tx_data,  8'h00);
    check({tag, "_tx_start"}, u_if.tx_start, 1'b0);
    check({tag, "_done"},     rx_tx_done,    1'b0);
    check({tag, "_local"},    local_square,  9'h000);
    check({tag, "_remote"},   remote_square, 9'h000);
    check({tag, "_rplayer"},  remote_player, 1'b0);
    check({tag, "_ferr"},     frame_err,     1'b0);
    check({tag, "_ovr"},      overrun,       1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int snap;
    rst = 1'b0; uart_en = 1'b0; uart_mode = 1'b0; playerID = 1'b0; mouse_left = 1'b0;
    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    u_if.tx_done = 1'b0; u_if.rx_valid = 1'b0; u_if.rx_data = 8'h00;
    @(negedge pclk);
    check_all_reset("reset");
    tick(2);
    rst = 1'b1;
    tick(1);

    // Send the clicked centre cell.
    click(400, 300);
    uart_en = 1'b1; uart_mode = 1'b0;
    wait_for(0, 10, seen);
    check("send_tx_start_seen", seen, 1'b1);
    check("send_tx_data",       u_if.tx_data, 8'hA4);
    check("send_local_square",  local_square, 9'h010);
    tick(2);
    u_if.tx_done = 1'b1;
    tick(1);
    u_if.tx_done = 1'b0;
    @(negedge pclk);
    check("send_done_latency", rx_tx_done, 1'b1);

    // Switch to receive without dropping uart_en.
    tick(1);
    uart_mode = 1'b1;
    tick(4);
    rx_byte(8'hB8);
    wait_for(1, 10, seen);
    check("recv_done_seen",    seen, 1'b1);
    check("recv_remote",       remote_square, 9'h100);
    check("recv_rplayer",      remote_player, 1'b1);
    tick(1);
    snap = n_done;
    tick(5);
    check("recv_single_pulse", n_done, snap);

    // Bad index frame, then a good one.
    uart_en = 1'b0;
    tick(2);
    uart_en = 1'b1;
    tick(3);
    rx_byte(8'hAC);
    wait_for(2, 10, seen);
    check("bad_frame_err_seen", seen, 1'b1);
    tick(1);
    snap = n_done;
    tick(3);
    check("bad_frame_no_done", n_done, snap);
    rx_byte(8'hA0);
    wait_for(1, 10, seen);
    check("good_after_bad_done", seen, 1'b1);
    check("good_after_bad_remote", remote_square, 9'h001);

    // Two bytes before the receive starts.
    uart_en = 1'b0;
    tick(3);
    u_if.rx_data = 8'hA1; u_if.rx_valid = 1'b1;
    tick(1);
    u_if.rx_data = 8'hA2;
    tick(1);
    u_if.rx_valid = 1'b0;
    wait_for(3, 5, seen);
    check("overrun_seen", seen, 1'b1);
    uart_en = 1'b1; uart_mode = 1'b1;
    wait_for(1, 10, seen);
    check("overrun_done_seen", seen, 1'b1);
    check("overrun_remote",    remote_square, 9'h004);

    // Send with only a gap click recorded.
    uart_en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    click(340, 100);
    tick(1);
    snap = n_txs;
    uart_en = 1'b1; uart_mode = 1'b0;
    wait_for(2, 10, seen);
    check("gap_frame_err_seen", seen, 1'b1);
    tick(6);
    check("gap_no_tx_start", n_txs, snap);
    check("gap_local_square", local_square, 9'h000);

    // Reset in the middle of a send.
    uart_en = 1'b0;
    tick(2);
    click(100, 100);
    uart_en = 1'b1; uart_mode = 1'b0;
    wait_for(0, 10, seen);
    check("midrst_tx_start_seen", seen, 1'b1);
    tick(1);
    rst = 1'b0; uart_en = 1'b0;
    @(negedge pclk);
    check_all_reset("midrst_async");
    tick(1);
    rst = 1'b1;
    snap = n_done;
    tick(2);
    u_if.tx_done = 1'b1;
    tick(1);
    u_if.tx_done = 1'b0;
    tick(3);
    check("midrst_no_done", n_done, snap);
    check_all_reset("midrst_after");

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/move_link.md
MOVE_LINK -- requirements
Module: move_link

Interface
REQ-001 pclk  input  1  system pixel clock; all state changes on its rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 uart_en  input  1  operation enable from control_unit.
REQ-004 uart_mode  input  1  0 = SENDING, 1 = RECEIVING.
REQ-005 playerID  input  1  local player bit, inserted into transmitted frames.
REQ-006 mouse_xpos, mouse_ypos  input  12 each  cursor position.
REQ-007 mouse_left  input  1  left button level.
REQ-008 tx_data  output  8  byte to the UART transmitter.
REQ-009 tx_start  output  1  one-cycle request to the UART transmitter.
REQ-010 tx_done  input  1  one-cycle pulse when the UART transmitter finishes a byte.
REQ-011 rx_data  input  8  byte from the UART receiver.
REQ-012 rx_valid  input  1  one-cycle pulse when rx_data is valid.
REQ-013 rx_tx_done  output  1  one-cycle pulse when an exchange completes.
REQ-014 local_square, remote_square  output  9 each  one-hot cell of the last sent and the last received move.
REQ-015 remote_player  output  1  player bit of the last received frame.
REQ-016 frame_err, overrun  output  1 each  one-cycle error pulses.

Function
REQ-017 Cells: columns x 0-338, 344-679, 685-1023; rows y 0-251, 259-507, 515-767; index = row*3 + col, range 0..8; gaps and out-of-range positions decode to no cell.
REQ-018 Click latch: any cycle with mouse_left = 1 on a valid cell stores that index as last_click (4 b, reset value 4'hF = none).
REQ-019 Frame format: {3'b101, player bit, idx[3:0]}.
REQ-020 The frame is valid only if bits [7:5] = 101 and idx <= 8.
REQ-021 FSM states: IDLE, LOAD, TX_WAIT, RX_WAIT, DONE, REARM.
REQ-022 IDLE: uart_en = 1 and uart_mode = 0 -> LOAD; uart_en = 1 and uart_mode = 1 -> RX_WAIT.
REQ-023 LOAD: if last_click = F, assert frame_err and go to REARM; otherwise drive tx_data = frame, pulse tx_start for one cycle, set local_square = onehot(last_click), then go to TX_WAIT.
REQ-024 TX_WAIT: on tx_done -> DONE.
REQ-025 RX_WAIT: consume the pending byte; a valid frame loads remote_square and remote_player, clears pending, then -> DONE.
REQ-026 RX_WAIT: an invalid frame pulses frame_err, clears pending, and the FSM stays in RX_WAIT.
REQ-027 DONE: pulse rx_tx_done for exactly one cycle, record last_mode = uart_mode, then -> REARM.
REQ-028 REARM: go to IDLE when uart_en = 0 or uart_mode != last_mode; this allows TX then RX without uart_en dropping.
REQ-029 Abort: uart_en = 0 in LOAD, TX_WAIT or RX_WAIT -> IDLE with no rx_tx_done pulse; a tx_done that arrives afterwards is ignored.
REQ-030 RX buffer: a one-entry holding register captures rx_data on every rx_valid in any state, including while transmitting, and sets pending.
REQ-031 If rx_valid arrives while pending = 1, the new byte overwrites the old one and overrun pulses.
REQ-032 Simultaneous events: if consume and a new rx_valid occur in the same cycle, the new byte is stored with pending = 1 and no overrun is raised.
REQ-033 tx_done outside TX_WAIT and rx_valid timing have no effect on the FSM state.
REQ-034 Latency: rx_tx_done is asserted 1 cycle after tx_done, or 1 cycle after a valid byte is consumed; a byte already pending is consumed on the first RX_WAIT cycle.

Reset
REQ-035 When rst = 0, all registers clear immediately: state = IDLE, tx_data = 0, tx_start = 0, rx_tx_done = 0, local_square = 0, remote_square = 0, remote_player = 0, frame_err = 0, overrun = 0, pending = 0, last_click = F, last_mode = 0.
REQ-036 Reset taken mid-transfer discards the transfer; no pulse is emitted on release.
REQ-037 All outputs are registered.

Structure
REQ-038 A shared package holds: cell boundary constants, the header 3'b101, the none-index 4'hF, the state encoding, and the SENDING/RECEIVING constants.
REQ-039 The combinational cell decode lives in one sub-module, square_decoder (inputs x, y; outputs idx[3:0], hit).

Verification
REQ-040 Click at (400,300), playerID = 0, then uart_en = 1, mode = 0 -> tx_start with tx_data = 8'hA4, local_square = 9'h010; tx_done -> rx_tx_done one cycle later.
REQ-041 After REQ-040, mode -> 1 with uart_en held at 1, then rx_valid with 8'hB8 -> remote_square = 9'h100, remote_player = 1, one rx_tx_done pulse.
REQ-042 rx_valid with 8'hAC (idx 12) in RX_WAIT -> frame_err pulse, no rx_tx_done; the FSM stays waiting, and a following 8'hA0 completes with remote_square = 9'h001.
REQ-043 Two rx_valid pulses (8'hA1 then 8'hA2) before RX_WAIT -> overrun pulse; the consumed frame gives remote_square = 9'h004.
REQ-044 Only clicks at (340,100) (gap) before a send -> frame_err and no tx_start.
REQ-045 rst = 0 during TX_WAIT, then tx_done after release -> no rx_tx_done; all outputs hold their reset values.
